// File: rtl/arith_pkg.sv
// Shared types and helpers for the arithmetic-unit front end: opcodes,
// sequencer states and the per-opcode operand count.
package arith_pkg;

    localparam int NUM_SLOTS = 3;

    typedef enum logic [2:0] {
        OP_DIV  = 3'b000,
        OP_SQRT = 3'b001,
        OP_MUL  = 3'b010,
        OP_MAC  = 3'b011
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ISSUE,
        BUSY
    } seq_state_t;

    // Reserved opcodes (1xx) report zero operands.
    function automatic logic [1:0] operand_count(input logic [2:0] op);
        case (op)
            OP_DIV:  operand_count = 2'd2;
            OP_SQRT: operand_count = 2'd1;
            OP_MUL:  operand_count = 2'd2;
            OP_MAC:  operand_count = 2'd3;
            default: operand_count = 2'd0;
        endcase
    endfunction

    function automatic logic is_reserved(input logic [2:0] op);
        is_reserved = op[2];
    endfunction

endpackage

// File: rtl/edge_detect.sv
// One-shot rising-edge detector: the edge is reported in the same cycle the
// level is first seen high, using a registered copy of the previous level.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_edge
);

    logic r_level_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) r_level_q <= 1'b0;
        else     r_level_q <= i_level;
    end

    assign o_edge = i_level & ~r_level_q;

endmodule

// File: rtl/operand_sequencer.sv
// Operand sequencer: captures an opcode and 1-3 sign-magnitude operands, then
// issues a start pulse to the datapath. Optional load watchdog: LOAD_TIMEOUT_EN.
module operand_sequencer
    import arith_pkg::*;
#(
    parameter int WORD_LENGTH    = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WORD_LENGTH-1:0]           data,
    input  logic [2:0]                       opCode,
    input  logic                             start,
    input  logic                             load,
    input  logic                             done_in,
    output logic [NUM_SLOTS*WORD_LENGTH-1:0] operand_mag,
    output logic [NUM_SLOTS-1:0]             operand_sign,
    output logic [NUM_SLOTS-1:0]             load_strobe,
    output logic [2:0]                       opCode_out,
    output logic [1:0]                       op_index,
    output logic                             start_out,
    output logic                             busy,
    output logic                             error,
    output logic                             timeout
);

    seq_state_t                       r_state, w_next_state;
    logic [2:0]                       r_opcode;
    logic [1:0]                       r_op_index;
    logic [NUM_SLOTS*WORD_LENGTH-1:0] r_mag;
    logic [NUM_SLOTS-1:0]             r_sign;
    logic [NUM_SLOTS-1:0]             r_strobe;
    logic                             r_error, r_timeout;

    logic                   w_start_edge, w_load_edge;
    logic                   w_last_load, w_check_fail, w_timeout_hit;
    logic [WORD_LENGTH-1:0] w_mag;

    edge_detect u_start_edge (.clk(clk), .rst(rst), .i_level(start), .o_edge(w_start_edge));
    edge_detect u_load_edge  (.clk(clk), .rst(rst), .i_level(load),  .o_edge(w_load_edge));

    // Most-negative input negates to itself, which is exactly 2^(W-1) unsigned.
    assign w_mag        = data[WORD_LENGTH-1] ? -data : data;
    assign w_last_load  = (r_op_index + 2'd1) == operand_count(r_opcode);
    assign w_check_fail = ((r_opcode == OP_DIV)  && (r_mag[WORD_LENGTH +: WORD_LENGTH] == '0)) ||
                          ((r_opcode == OP_SQRT) && r_sign[0]);

`ifdef LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_idle_cnt;

    // Held at zero outside LOAD, so entering LOAD starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst || (r_state != LOAD) || w_load_edge) r_idle_cnt <= '0;
        else                                         r_idle_cnt <= r_idle_cnt + CNT_W'(1);
    end

    assign w_timeout_hit = (r_state == LOAD) && !w_load_edge &&
                           (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default assignment first keeps this combinational block latch-free.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_edge && !is_reserved(opCode)) w_next_state = LOAD;
            LOAD: begin
                if (w_timeout_hit)                   w_next_state = IDLE;
                else if (w_load_edge && w_last_load) w_next_state = CHECK;
            end
            CHECK:   w_next_state = w_check_fail ? IDLE : ISSUE;
            ISSUE:   w_next_state = BUSY;
            BUSY:    if (done_in) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        start_out = (r_state == ISSUE);
        busy      = (r_state == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opcode   <= '0;
            r_op_index <= '0;
            r_mag      <= '0;
            r_sign     <= '0;
            r_strobe   <= '0;
            r_error    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_strobe <= '0;
            case (r_state)
                IDLE: if (w_start_edge) begin
                    r_opcode   <= opCode;
                    r_op_index <= '0;
                    r_error    <= is_reserved(opCode);
                    r_timeout  <= 1'b0;
                end
                LOAD: if (w_load_edge) begin
                    r_mag[r_op_index*WORD_LENGTH +: WORD_LENGTH] <= w_mag;
                    r_sign[r_op_index]                           <= data[WORD_LENGTH-1];
                    r_strobe                                     <= 3'b001 << r_op_index;
                    r_op_index                                   <= r_op_index + 2'd1;
                end else if (w_timeout_hit) begin
                    r_timeout <= 1'b1;
                    r_error   <= 1'b1;
                end
                CHECK: if (w_check_fail) r_error <= 1'b1;
                default: ;
            endcase
        end
    end

    assign operand_mag  = r_mag;
    assign operand_sign = r_sign;
    assign load_strobe  = r_strobe;
    assign opCode_out   = r_opcode;
    assign op_index     = r_op_index;
    assign error        = r_error;
    assign timeout      = r_timeout;

endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
- Parametrised successor to the two-operand input controller feeding the arithmetic unit (div/sqrt/mul).
- Captures a multi-bit opcode, then 1–3 operands from a shared data bus on load edges.
- Converts each operand from two's complement to sign-magnitude and validates it.
- Issues a start pulse to the datapath and holds busy until the datapath reports done; adds the MAC mode, the done handshake and a reserved-opcode error.

Parameters:
- WORD_LENGTH, 8: operand width in bits (two's complement in, magnitude out); minimum 2.
- TIMEOUT_CYCLES, 1000000: idle cycles allowed between loads before abort; used only with LOAD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- data  in  WORD_LENGTH  operand in two's complement
- opCode  in  3  operation code, sampled on start edge
- start  in  1  level input (button); rising edge begins an operation
- load  in  1  level input (button); rising edge captures data into the next operand slot
- done_in  in  1  datapath completion, 1-cycle pulse
- operand_mag  out  3*WORD_LENGTH  slot k at bits [k*WORD_LENGTH +: WORD_LENGTH]
- operand_sign  out  3  sign per slot, 1 = negative
- load_strobe  out  3  1-cycle pulse on the cycle after slot k is written
- opCode_out  out  3  registered opcode
- op_index  out  2  next slot to be loaded
- start_out  out  1  1-cycle datapath start
- busy  out  1  high from start_out until done_in
- error  out  1  sticky error
- timeout  out  1  sticky abort flag

Interface decision: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.

Behaviour:
- Reset (rst high at a clk edge): state IDLE.
  - All outputs 0, operand registers 0, edge-detector history 0.
  - Reset mid-operation abandons it; no start_out is emitted.
- Edge detection: start_edge = start & ~start_q and load_edge = load & ~load_q, where *_q is the input registered every cycle.
  - An event acts on the same clk edge at which the input is first sampled high.
- Operand count from opCode_out:
  - 000 DIV: 2 operands.
  - 001 SQRT: 1 operand.
  - 010 MUL: 2 operands.
  - 011 MAC (a*b+c): 3 operands.
  - 1xx: reserved.
- IDLE:
  - On start_edge: register opCode, clear error and timeout, set op_index = 0.
  - Reserved opcode: set error and stay in IDLE.
  - Otherwise go to LOAD.
  - load_edge and done_in are ignored in IDLE.
- LOAD:
  - On load_edge, slot[op_index] receives magnitude = |data| and sign = data MSB, then op_index increments.
  - Most-negative input: magnitude is 2^(WORD_LENGTH-1) and sign is 1, e.g. 0x80 -> 0x80/1.
  - Once op_index reaches the operand count, go to CHECK.
  - start_edge is ignored in LOAD. Unused slots keep their old values.
- CHECK (1 cycle):
  - DIV with slot1 magnitude 0 -> error.
  - SQRT with slot0 sign 1 -> error.
  - On error, go to IDLE with no start_out; otherwise go to ISSUE.
- ISSUE (1 cycle): start_out = 1, then go to BUSY.
- BUSY:
  - busy = 1 while in BUSY.
  - done_in -> IDLE, with busy low in the following cycle.
  - start_edge and load_edge are ignored.
- Latency: 2 cycles from the clk edge accepting the final load to start_out high (CHECK, then ISSUE).
- Simultaneous start_edge and load_edge in IDLE: start is taken, load is discarded.
- error and timeout stay high until the next accepted start_edge or reset.

Optional Feature:
- Macro: LOAD_TIMEOUT_EN.
- When defined:
  - A counter runs in LOAD and restarts on every accepted load_edge and on entry to LOAD.
  - After TIMEOUT_CYCLES consecutive cycles without a load: set timeout and error, go to IDLE, no start_out.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- When undefined: LOAD waits indefinitely, timeout is tied to 0, and no counter is built.

Decomposition:
- Shared package arith_pkg:
  - opcode enum (OP_DIV, OP_SQRT, OP_MUL, OP_MAC).
  - seq_state_t enum (IDLE, LOAD, CHECK, ISSUE, BUSY).
  - NUM_SLOTS = 3.
  - Function operand_count(opcode).
- Sub-module edge_detect: one-shot rising-edge detector with registered history, sync reset; two instances (start, load).
- Two's-complement-to-magnitude conversion is inline.

Test Plan:
- DIV: opCode=000, loads 0xF6 then 0x02 -> slot0 mag 0x0A sign 1, slot1 mag 0x02 sign 0; start_out one pulse 2 cycles after second load; busy until done_in; error 0.
- DIV by zero: loads 0x05, 0x00 -> error 1, no start_out, IDLE; next start_edge clears error.
- SQRT: opCode=001, single load 0x80 -> mag 0x80, sign 1, error 1, no start_out. Repeat with 0x10 -> start_out after one load.
- MAC: opCode=011, loads 0x03, 0xFF, 0x7F -> three load_strobe pulses (bits 0, 1, 2 in order), then start_out. Extra load_edge and start_edge during BUSY are ignored.
- Reserved opCode=101: start_edge -> error 1, state stays IDLE, load_edge ignored. Same-cycle start+load edges in IDLE -> op_index stays 0.
- rst high mid-LOAD after one load -> all outputs 0 next cycle, no start_out. With LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=16: no load for 16 cycles -> timeout=1, error=1.
